// File: rtl/pipe_id_ex.sv
// pipe_id_ex: ID/EX pipeline register with operand forwarding select and bubble insertion; PIPE_PERF_CNT_EN adds stall/flush counters.
module pipe_id_ex #(
    parameter int XLEN    = 32,
    parameter int ALUOP_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stop,
    input  logic               flush,
    input  logic               id_valid,
    input  logic [XLEN-1:0]    id_pc,
    input  logic [XLEN-1:0]    id_pc4,
    input  logic [XLEN-1:0]    id_rf_rD1,
    input  logic [XLEN-1:0]    id_rf_rD2,
    input  logic               rs1_hazard,
    input  logic               rs2_hazard,
    input  logic [XLEN-1:0]    hazard_rD1,
    input  logic [XLEN-1:0]    hazard_rD2,
    input  logic [XLEN-1:0]    id_ext,
    input  logic [4:0]         id_wR,
    input  logic               id_rf_we,
    input  logic [1:0]         id_rf_wsel,
    input  logic [ALUOP_W-1:0] id_alu_op,
    input  logic               id_alub_sel,
    input  logic               id_ram_we,
    input  logic               id_branch,
    input  logic               id_jump,
    output logic               ex_valid,
    output logic [XLEN-1:0]    ex_pc,
    output logic [XLEN-1:0]    ex_pc4,
    output logic [XLEN-1:0]    ex_rD1,
    output logic [XLEN-1:0]    ex_rD2,
    output logic [XLEN-1:0]    ex_ext,
    output logic [4:0]         ex_wR,
    output logic               ex_rf_we,
    output logic               ex_alub_sel,
    output logic               ex_ram_we,
    output logic               ex_branch,
    output logic               ex_jump,
    output logic [1:0]         ex_rf_wsel,
    output logic [ALUOP_W-1:0] ex_alu_op
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0]        perf_stall_cnt,
    output logic [31:0]        perf_flush_cnt
`endif
);
    logic [XLEN-1:0] rd1_n, rd2_n;
    logic            load;
    assign rd1_n = rs1_hazard ? hazard_rD1 : id_rf_rD1;
    assign rd2_n = rs2_hazard ? hazard_rD2 : id_rf_rD2;
    assign load  = id_valid && !stop && !flush;
    // A bubble zeroes every field, giving an x0-targeting NOP with rf_wsel=ALUC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_pc4      <= '0;
            ex_rD1      <= '0;
            ex_rD2      <= '0;
            ex_ext      <= '0;
            ex_wR       <= '0;
            ex_rf_we    <= 1'b0;
            ex_alub_sel <= 1'b0;
            ex_ram_we   <= 1'b0;
            ex_branch   <= 1'b0;
            ex_jump     <= 1'b0;
            ex_rf_wsel  <= '0;
            ex_alu_op   <= '0;
        end else begin
            ex_valid    <= load;
            ex_pc       <= load ? id_pc : '0;
            ex_pc4      <= load ? id_pc4 : '0;
            ex_rD1      <= load ? rd1_n : '0;
            ex_rD2      <= load ? rd2_n : '0;
            ex_ext      <= load ? id_ext : '0;
            ex_wR       <= load ? id_wR : '0;
            ex_rf_we    <= load && id_rf_we;
            ex_alub_sel <= load && id_alub_sel;
            ex_ram_we   <= load && id_ram_we;
            ex_branch   <= load && id_branch;
            ex_jump     <= load && id_jump;
            ex_rf_wsel  <= load ? id_rf_wsel : '0;
            ex_alu_op   <= load ? id_alu_op : '0;
        end
    end
`ifdef PIPE_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else if (flush) begin
            perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end else if (stop) begin
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_pipe_id_ex.sv
// tb_pipe_id_ex: directed self-checking bench for the ID/EX pipeline register.
module tb_pipe_id_ex;
    logic        clk = 1'b0;
    logic        rst_n, stop, flush, id_valid;
    logic [31:0] id_pc, id_pc4, id_rf_rD1, id_rf_rD2, hazard_rD1, hazard_rD2, id_ext;
    logic        rs1_hazard, rs2_hazard;
    logic [4:0]  id_wR;
    logic        id_rf_we, id_alub_sel, id_ram_we, id_branch, id_jump;
    logic [1:0]  id_rf_wsel;
    logic [3:0]  id_alu_op;
    logic        ex_valid, ex_rf_we, ex_alub_sel, ex_ram_we, ex_branch, ex_jump;
    logic [31:0] ex_pc, ex_pc4, ex_rD1, ex_rD2, ex_ext;
    logic [4:0]  ex_wR;
    logic [1:0]  ex_rf_wsel;
    logic [3:0]  ex_alu_op;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif
    int errors = 0;
    int checks = 0;

    pipe_id_ex dut (
        .clk(clk), .rst_n(rst_n), .stop(stop), .flush(flush), .id_valid(id_valid),
        .id_pc(id_pc), .id_pc4(id_pc4), .id_rf_rD1(id_rf_rD1), .id_rf_rD2(id_rf_rD2),
        .rs1_hazard(rs1_hazard), .rs2_hazard(rs2_hazard),
        .hazard_rD1(hazard_rD1), .hazard_rD2(hazard_rD2), .id_ext(id_ext),
        .id_wR(id_wR), .id_rf_we(id_rf_we), .id_rf_wsel(id_rf_wsel), .id_alu_op(id_alu_op),
        .id_alub_sel(id_alub_sel), .id_ram_we(id_ram_we), .id_branch(id_branch), .id_jump(id_jump),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_pc4(ex_pc4), .ex_rD1(ex_rD1), .ex_rD2(ex_rD2),
        .ex_ext(ex_ext), .ex_wR(ex_wR), .ex_rf_we(ex_rf_we), .ex_alub_sel(ex_alub_sel),
        .ex_ram_we(ex_ram_we), .ex_branch(ex_branch), .ex_jump(ex_jump),
        .ex_rf_wsel(ex_rf_wsel), .ex_alu_op(ex_alu_op)
`ifdef PIPE_PERF_CNT_EN
        , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [31:0] pc, input logic [4:0] wr, input logic rf_we, input logic ram_we);
        id_valid    = 1'b1;
        id_pc       = pc;
        id_pc4      = pc + 32'd4;
        id_wR       = wr;
        id_rf_we    = rf_we;
        id_ram_we   = ram_we;
        id_ext      = 32'h0000_0ABC;
        id_rf_wsel  = 2'd3;
        id_alu_op   = 4'hA;
        id_alub_sel = 1'b1;
        id_branch   = 1'b1;
        id_jump     = 1'b1;
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, ".valid"}, {31'd0, ex_valid}, 32'd0);
        chk({tag, ".rf_we"}, {31'd0, ex_rf_we}, 32'd0);
        chk({tag, ".ram_we"}, {31'd0, ex_ram_we}, 32'd0);
        chk({tag, ".br_jmp"}, {30'd0, ex_branch, ex_jump}, 32'd0);
        chk({tag, ".wR"}, {27'd0, ex_wR}, 32'd0);
        chk({tag, ".pc"}, ex_pc, 32'd0);
        chk({tag, ".misc"}, {25'd0, ex_rf_wsel, ex_alu_op, ex_alub_sel}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; stop = 1'b0; flush = 1'b0; id_valid = 1'b0;
        id_pc = '0; id_pc4 = '0; id_rf_rD1 = 32'h11; id_rf_rD2 = 32'h22;
        rs1_hazard = 1'b0; rs2_hazard = 1'b0; hazard_rD1 = 32'hCAFE_F00D; hazard_rD2 = 32'hDEAD_BEEF;
        id_ext = '0; id_wR = '0; id_rf_we = 1'b0; id_rf_wsel = '0; id_alu_op = '0;
        id_alub_sel = 1'b0; id_ram_we = 1'b0; id_branch = 1'b0; id_jump = 1'b0;
        step();
        chk_bubble("reset");
        rst_n = 1'b1;
        instr(32'h100, 5'd5, 1'b1, 1'b0);
        step();
        chk("load.valid", {31'd0, ex_valid}, 32'd1);
        chk("load.pc", ex_pc, 32'h100);
        chk("load.pc4", ex_pc4, 32'h104);
        chk("load.wR", {27'd0, ex_wR}, 32'd5);
        chk("load.rD1", ex_rD1, 32'h11);
        chk("load.rD2", ex_rD2, 32'h22);
        chk("load.ext", ex_ext, 32'hABC);
        chk("load.ctl", {24'd0, ex_rf_we, ex_alub_sel, ex_ram_we, ex_branch, ex_jump, ex_rf_wsel, 1'b0}, 32'hDE);
        chk("load.aluop", {28'd0, ex_alu_op}, 32'hA);
        rs2_hazard = 1'b1;
        step();
        chk("fwd2.on", ex_rD2, 32'hDEAD_BEEF);
        chk("fwd2.rD1", ex_rD1, 32'h11);
        rs2_hazard = 1'b0; rs1_hazard = 1'b1;
        step();
        chk("fwd2.off", ex_rD2, 32'h22);
        chk("fwd1.on", ex_rD1, 32'hCAFE_F00D);
        rs1_hazard = 1'b0;
        instr(32'h200, 5'd7, 1'b1, 1'b1);
        stop = 1'b1;
        step();
        chk_bubble("stall");
        step();
        chk_bubble("stall2");
        stop = 1'b0;
        step();
        chk("resume.valid", {31'd0, ex_valid}, 32'd1);
        chk("resume.wR", {27'd0, ex_wR}, 32'd7);
        chk("resume.ram_we", {31'd0, ex_ram_we}, 32'd1);
        chk("resume.pc", ex_pc, 32'h200);
        flush = 1'b1; stop = 1'b1;
        step();
        chk_bubble("flush_stop");
`ifdef PIPE_PERF_CNT_EN
        chk("perf.flush", perf_flush_cnt, 32'd1);
        chk("perf.stall", perf_stall_cnt, 32'd2);
`endif
        stop = 1'b0;
        step();
        chk_bubble("flush");
        flush = 1'b0; id_valid = 1'b0;
        step();
        chk_bubble("invalid");
        instr(32'h300, 5'd9, 1'b1, 1'b0);
        step();
        chk("pre_rst.valid", {31'd0, ex_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_bubble("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_rst.valid", {31'd0, ex_valid}, 32'd1);
        chk("post_rst.pc", ex_pc, 32'h300);
`ifdef PIPE_PERF_CNT_EN
        chk("perf.rst", perf_stall_cnt | perf_flush_cnt, 32'd0);
        force dut.perf_stall_cnt = 32'hFFFF_FFFF;
        #1 release dut.perf_stall_cnt;
        stop = 1'b1;
        step();
        chk("perf.wrap", perf_stall_cnt, 32'd0);
        stop = 1'b0;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pipe_id_ex.md
Name: pipe_id_ex

Overview:
- ID/EX pipeline register of the 5-stage RV32I pipeline, directly downstream of the hazard/forwarding unit.
- Selects forwarded or register-file operands per source using rs1_hazard/rs2_hazard.
- Inserts a bubble on load-use stop and on control flush; otherwise latches all ID-stage data/control into EX.
- Its ex_* outputs feed the EX stage and loop back to the hazard unit's EX-side inputs.

Parameters:
- XLEN, 32, datapath width
- ALUOP_W, 4, ALU opcode width

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- stop  in  1  load-use stall from hazard unit; insert bubble
- flush  in  1  taken branch/jump resolved in EX; kill ID instruction
- id_valid  in  1  ID holds a real instruction
- id_pc  in  XLEN  ID instruction PC
- id_pc4  in  XLEN  id_pc+4
- id_rf_rD1  in  XLEN  register-file read data, rs1
- id_rf_rD2  in  XLEN  register-file read data, rs2
- rs1_hazard  in  1  use hazard_rD1 for rs1
- rs2_hazard  in  1  use hazard_rD2 for rs2
- hazard_rD1  in  XLEN  forwarded rs1 value
- hazard_rD2  in  XLEN  forwarded rs2 value
- id_ext  in  XLEN  sign-extended immediate
- id_wR  in  5  destination register
- id_rf_we  in  1  register write enable
- id_rf_wsel  in  2  writeback select: 0 ALUC, 1 RAM, 2 EXT, 3 PC4
- id_alu_op  in  ALUOP_W  ALU operation
- id_alub_sel  in  1  ALU B: 0 rD2, 1 ext
- id_ram_we  in  1  store enable
- id_branch  in  1  conditional branch
- id_jump  in  1  jal/jalr
- ex_valid  out  1  EX holds a real instruction
- ex_pc, ex_pc4, ex_rD1, ex_rD2, ex_ext  out  XLEN  registered copies
- ex_wR  out  5  registered destination
- ex_rf_we, ex_alub_sel, ex_ram_we, ex_branch, ex_jump  out  1  registered controls
- ex_rf_wsel  out  2  registered writeback select
- ex_alu_op  out  ALUOP_W  registered ALU op

Behaviour:
- All outputs are registers; every output resets to 0 asynchronously when rst_n=0; reset release is clocked by clk only.
- Operand select (combinational, before the register): rD1_n = rs1_hazard ? hazard_rD1 : id_rf_rD1; same for rs2. The rsX_hazard inputs already qualify stop; no further gating.
- Each rising edge, priority (highest first):
  1. flush=1 -> bubble
  2. stop=1 -> bubble
  3. id_valid=0 -> bubble
  4. else load all id_* fields plus rD1_n/rD2_n; ex_valid=1.
- Bubble: ex_valid, ex_rf_we, ex_ram_we, ex_branch and ex_jump = 0; all other data/control outputs = 0, making the bubble an x0-targeting NOP with rf_wsel=ALUC.
- Latency: 1 cycle from ID inputs to ex_* outputs.
- Never holds. Upstream PC and IF/ID freeze on stop; this stage always advances.
- stop and flush together: bubble, accounted as flush.
- ex_wR of a bubble is 0, so the hazard unit sees no EX-stage hazard in the cycle after a bubble.
- Back-to-back stops produce consecutive bubbles; no state carries between them.
- Reset mid-stream discards the in-flight instruction; the first post-reset edge follows the normal priority.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN
- Defined: adds outputs perf_stall_cnt[31:0] and perf_flush_cnt[31:0], both reset to 0.
  - On each edge with flush=1, perf_flush_cnt increments.
  - Else, on each edge with stop=1, perf_stall_cnt increments.
  - Both wrap from 0xFFFFFFFF to 0.
- Undefined: ports and counters absent; core behaviour identical.

Test Plan:
- Reset: rst_n=0 asynchronously while ex_valid=1 and ex_rf_we=1 -> all outputs 0 immediately, before the next edge.
- Normal load: id_valid=1, id_pc=0x100, id_wR=5, id_rf_we=1, id_rf_rD1=0x11, rs1_hazard=0, edge -> ex_pc=0x100, ex_wR=5, ex_rD1=0x11, ex_valid=1.
- Forwarding: rs2_hazard=1, hazard_rD2=0xDEADBEEF, id_rf_rD2=0x22 -> ex_rD2=0xDEADBEEF; with rs2_hazard=0 -> 0x22.
- Load-use stall: stop=1 with valid ID (id_wR=7, id_ram_we=1) -> ex_valid=0, ex_rf_we=0, ex_ram_we=0, ex_wR=0. stop=0 next edge -> instruction loads with ex_wR=7.
- Flush vs stop: flush=1 and stop=1 same edge -> bubble. With PIPE_PERF_CNT_EN: perf_flush_cnt 0->1, perf_stall_cnt stays 0.
- Counter wrap: force perf_stall_cnt=0xFFFFFFFF, apply stop=1 -> 0x00000000.
